// File: rtl/n64adv_cparams.sv
// ----------------------------------------------------------------------------
// n64adv_cparams
// Shared constants for the controller-side logic: IGR command encodings, the
// FSM state type, the button combos that trigger each command, and the mask
// that drops JR and the reserved bit from the sniffed button word.
// Button word layout: [7:0] = A,B,Z,St,Du,Dd,Dl,Dr ; [15:8] = JR,0,L,R,Cu,Cd,Cl,Cr
// ----------------------------------------------------------------------------
package n64adv_cparams;

    typedef enum logic [1:0] {
        CMD_NONE       = 2'd0,
        CMD_RESET      = 2'd1,
        CMD_FALLBACK   = 2'd2,
        CMD_OSD_TOGGLE = 2'd3
    } igr_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_HOLD         = 2'd1,
        ST_FIRE         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } igr_state_t;

    localparam logic [15:0] IGR_BTN_MASK = 16'hFCFF;

    // A + B + Z + Start + R
    localparam logic [15:0] IGR_RESET    = 16'h080F;
    // D-down + L + R + C-down
    localparam logic [15:0] IGR_FALLBACK = 16'h2C20;
    // D-up + L + R + C-up
    localparam logic [15:0] IGR_OSD      = 16'h1C10;

    // Priority order matters only if combos ever overlap; today they are
    // exact-match constants and mutually exclusive.
    function automatic igr_cmd_t igr_match(input logic [15:0] btn);
        if (btn == IGR_RESET)
            return CMD_RESET;
        else if (btn == IGR_FALLBACK)
            return CMD_FALLBACK;
        else if (btn == IGR_OSD)
            return CMD_OSD_TOGGLE;
        return CMD_NONE;
    endfunction

    // Stick bytes arrive MSB-last on the wire.
    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = v[7-i];
        return r;
    endfunction

endpackage

// File: rtl/ctrl_igr_decoder_stick_nav.sv
// ----------------------------------------------------------------------------
// igr_stick_nav
// Turns the analog stick into OSD navigation pulses. Built only when
// IGR_ANALOG_NAV_EN is defined.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_valid          poll strobe; stick bytes are stable while high
//   i_x_raw/i_y_raw  stick bytes as sniffed (bit-reversed)
//   i_pulse_en       pulses allowed (decoder idle)
//   o_nav            {up,down,left,right} one-cycle pulses
// ----------------------------------------------------------------------------
module igr_stick_nav
    import n64adv_cparams::*;
#(
    parameter logic [7:0] STICK_TH = 8'd64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_x_raw,
    input  logic [7:0] i_y_raw,
    input  logic       i_pulse_en,
    output logic [3:0] o_nav
);

    logic [7:0]        w_x_byte;
    logic [7:0]        w_y_byte;
    logic signed [9:0] w_x;
    logic signed [9:0] w_y;
    logic signed [9:0] w_th;
    logic [3:0]        w_beyond;
    logic [3:0]        r_flags;

    assign w_x_byte = bit_rev8(i_x_raw);
    assign w_y_byte = bit_rev8(i_y_raw);

    // Two spare bits keep -128 and -STICK_TH representable without wrap.
    assign w_x  = {{2{w_x_byte[7]}}, w_x_byte};
    assign w_y  = {{2{w_y_byte[7]}}, w_y_byte};
    assign w_th = {2'b00, STICK_TH};

    assign w_beyond = {w_y >= w_th, w_y <= -w_th, w_x <= -w_th, w_x >= w_th};

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_flags <= 4'b0;
        else if (i_valid)
            r_flags <= w_beyond;
    end

    assign o_nav = (i_valid && i_pulse_en && !i_rst) ? (w_beyond & ~r_flags) : 4'b0;

endmodule

// File: rtl/ctrl_igr_decoder.sv
// ----------------------------------------------------------------------------
// ctrl_igr_decoder
// Watches sniffed controller polls for held IGR button combos and emits one
// command strobe per hold; owns the timed N64 reset drive.
// Optional: IGR_ANALOG_NAV_EN adds stick-derived OSD navigation pulses;
// without it nav_o is tied low.
// Ports:
//   CTRL_CLK_i, CTRL_RST_i  controller clock, synchronous active-high reset
//   ctrl_data_i             sniffed 32-bit poll word
//   ctrl_data_valid_i       one-cycle poll strobe
//   ctrl_detected_i         controller present
//   use_igr_i               allows the RESET command to drive reset
//   cmd_valid_o, cmd_o      command strobe and code (code holds between strobes)
//   drv_rst_o               request to hold N64 reset low
//   nav_o                   {up,down,left,right} pulses
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | no combo being held
// HOLD         | counting consecutive polls of the candidate combo
// FIRE         | one cycle: command strobe out
// WAIT_RELEASE | command fired; waits for an all-released poll
// ----------------------------------------------------------------------------
module ctrl_igr_decoder
    import n64adv_cparams::*;
#(
    parameter logic [7:0]  HOLD_SAMPLES   = 8'd30,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd400000,
    parameter logic [19:0] RST_LEN        = 20'hFFFFF,
    parameter logic [7:0]  STICK_TH       = 8'd64
) (
    input  logic        CTRL_CLK_i,
    input  logic        CTRL_RST_i,
    input  logic [31:0] ctrl_data_i,
    input  logic        ctrl_data_valid_i,
    input  logic        ctrl_detected_i,
    input  logic        use_igr_i,
    output logic        cmd_valid_o,
    output logic [1:0]  cmd_o,
    output logic        drv_rst_o,
    output logic [3:0]  nav_o
);

    logic [15:0] w_btn;
    igr_state_t  r_state, w_state_nxt;
    igr_cmd_t    r_cand, w_cand_nxt;
    logic [7:0]  r_hold_cnt, w_hold_nxt;
    logic [23:0] r_tmo_cnt;
    logic        w_abort;
    logic        r_smp_vld;
    igr_cmd_t    r_smp_cmd;
    logic        r_smp_zero;
    igr_cmd_t    r_cmd;
    logic        r_drv_rst;
    logic [19:0] r_rst_cnt;
    logic        w_rst_trig;

    assign w_btn = ctrl_data_i[15:0] & IGR_BTN_MASK;

    // Registered match stage; the FSM acts on it one cycle after the poll.
    always_ff @(posedge CTRL_CLK_i) begin
        if (CTRL_RST_i) begin
            r_smp_vld  <= 1'b0;
            r_smp_cmd  <= CMD_NONE;
            r_smp_zero <= 1'b0;
        end else begin
            r_smp_vld <= ctrl_data_valid_i;
            if (ctrl_data_valid_i) begin
                r_smp_cmd  <= igr_match(w_btn);
                r_smp_zero <= (w_btn == 16'h0000);
            end
        end
    end

    always_ff @(posedge CTRL_CLK_i) begin
        if (CTRL_RST_i)
            r_tmo_cnt <= 24'd0;
        else if (ctrl_data_valid_i)
            r_tmo_cnt <= 24'd0;
        else if (r_tmo_cnt != TIMEOUT_CYCLES)
            r_tmo_cnt <= r_tmo_cnt + 24'd1;
    end

    // A poll arriving in the expiry cycle keeps the hold alive.
    assign w_abort = !ctrl_detected_i ||
                     ((r_tmo_cnt == TIMEOUT_CYCLES) && !ctrl_data_valid_i);

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_hold_nxt  = r_hold_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (r_smp_vld && ctrl_detected_i && (r_smp_cmd != CMD_NONE)) begin
                    w_cand_nxt  = r_smp_cmd;
                    w_hold_nxt  = 8'd1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_abort) begin
                    w_hold_nxt  = 8'd0;
                    w_state_nxt = ST_IDLE;
                end else if (r_smp_vld) begin
                    if (r_smp_cmd == r_cand) begin
                        w_hold_nxt = r_hold_cnt + 8'd1;
                        if (r_hold_cnt + 8'd1 == HOLD_SAMPLES)
                            w_state_nxt = ST_FIRE;
                    end else if (r_smp_cmd != CMD_NONE) begin
                        w_cand_nxt = r_smp_cmd;
                        w_hold_nxt = 8'd1;
                    end else begin
                        w_hold_nxt  = 8'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FIRE: begin
                w_hold_nxt  = 8'd0;
                w_state_nxt = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (w_abort || (r_smp_vld && r_smp_zero))
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_hold_nxt  = 8'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CTRL_CLK_i) begin
        if (CTRL_RST_i) begin
            r_state    <= ST_IDLE;
            r_cand     <= CMD_NONE;
            r_hold_cnt <= 8'd0;
            r_cmd      <= CMD_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_cand     <= w_cand_nxt;
            r_hold_cnt <= w_hold_nxt;
            // Load the code on entry to FIRE so it is valid with the strobe.
            if (w_state_nxt == ST_FIRE)
                r_cmd <= r_cand;
        end
    end

    assign cmd_valid_o = (r_state == ST_FIRE);
    assign cmd_o       = r_cmd;

    assign w_rst_trig = (r_state == ST_FIRE) && (r_cand == CMD_RESET) && use_igr_i;

    // Down-counter; a fire while the pulse is running is ignored.
    always_ff @(posedge CTRL_CLK_i) begin
        if (CTRL_RST_i) begin
            r_drv_rst <= 1'b0;
            r_rst_cnt <= 20'd0;
        end else if (r_drv_rst) begin
            if (r_rst_cnt == 20'd0)
                r_drv_rst <= 1'b0;
            else
                r_rst_cnt <= r_rst_cnt - 20'd1;
        end else if (w_rst_trig) begin
            r_drv_rst <= 1'b1;
            r_rst_cnt <= RST_LEN - 20'd1;
        end
    end

    assign drv_rst_o = r_drv_rst;

`ifdef IGR_ANALOG_NAV_EN
    igr_stick_nav #(
        .STICK_TH (STICK_TH)
    ) u_stick_nav (
        .i_clk      (CTRL_CLK_i),
        .i_rst      (CTRL_RST_i),
        .i_valid    (ctrl_data_valid_i),
        .i_x_raw    (ctrl_data_i[23:16]),
        .i_y_raw    (ctrl_data_i[31:24]),
        .i_pulse_en (r_state == ST_IDLE),
        .o_nav      (nav_o)
    );
`else
    // Stick bytes and threshold are deliberately unused in this build.
    logic w_unused_stick;
    assign w_unused_stick = ^{ctrl_data_i[31:16], STICK_TH};
    assign nav_o = 4'b0;
`endif

endmodule
